// File: rtl/tivi_bus_pkg.sv
// rtl/tivi_bus_pkg.sv - shared types and constants for the tivi register bus master
package tivi_bus_pkg;

   // Bus cycle phases of the master FSM
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      TURN
   } state_t;

   // One queued bus request
   typedef struct packed {
      logic       write;
      logic [3:0] rs;
      logic [7:0] wdata;
   } bus_req_t;

   // Register-select map shared with the tivi bus responder
   localparam logic [3:0] RS_ID     = 4'h0;
   localparam logic [3:0] RS_CTRL   = 4'h1;
   localparam logic [3:0] RS_STATUS = 4'h2;
   localparam logic [3:0] RS_DATA   = 4'h3;
   localparam logic [3:0] RS_IRQ    = 4'h7;

   // Phase counter reload value: a phase of n cycles counts n-1 down to 0
   function automatic logic [3:0] cnt_load(input int n);
      return 4'(n - 1);
   endfunction

endpackage

// File: rtl/tivi_bus_master_if.sv
// rtl/tivi_bus_master_if.sv - request/response and tivi bus signal bundle
interface tivi_bus_master_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [3:0] req_rs;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;
   logic       csb;
   logic       rdb;
   logic       wrb;
   logic [3:0] rs;
   logic [7:0] db_out;
   logic       db_oe;
   logic [7:0] db_in;

   // Bus master side
   modport master (
      input  req_valid, req_write, req_rs, req_wdata, db_in,
      output req_ready, rsp_valid, rsp_rdata, busy,
      output csb, rdb, wrb, rs, db_out, db_oe
   );

   // Requester / responder side
   modport slave (
      output req_valid, req_write, req_rs, req_wdata, db_in,
      input  req_ready, rsp_valid, rsp_rdata, busy,
      input  csb, rdb, wrb, rs, db_out, db_oe
   );
endinterface

// File: rtl/tivi_req_fifo.sv
// rtl/tivi_req_fifo.sv - 4-entry request queue in front of the bus master FSM
module tivi_req_fifo
   import tivi_bus_pkg::*;
(
   input  logic     clk,
   input  logic     resetb,
   input  logic     push,
   input  bus_req_t push_data,
   input  logic     pop,
   output bus_req_t pop_data,
   output logic     full,
   output logic     empty
);

   bus_req_t   mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       do_push;
   logic       do_pop;

   assign full     = (count == 3'd4);
   assign empty    = (count == 3'd0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; reset flushes the queue
   always_ff @(posedge clk) begin
      if (!resetb) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tivi_bus_master.sv
// rtl/tivi_bus_master.sv - tivi bus initiator with timed strobes; TIVI_BUSM_FIFO_EN adds a request FIFO
module tivi_bus_master
   import tivi_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2
) (
   input  logic               clk,
   input  logic               resetb,
   tivi_bus_master_if.master  bus
);

   if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
       HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
      $error("tivi_bus_master: SETUP_CYC/STROBE_CYC/HOLD_CYC must be in 1..15");
   end

   state_t     state;
   logic [3:0] cnt;
   logic       lat_write;
   logic       csb_q;
   logic       rdb_q;
   logic       wrb_q;
   logic       oe_q;
   logic       rsp_valid_q;
   logic [3:0] rs_q;
   logic [7:0] db_out_q;
   logic [7:0] rdata_q;
   logic       start;
   bus_req_t   next_req;
   bus_req_t   in_req;

   assign in_req = {bus.req_write, bus.req_rs, bus.req_wdata};

`ifdef TIVI_BUSM_FIFO_EN
   bus_req_t head;
   logic     fifo_full;
   logic     fifo_empty;
   logic     push;
   logic     pop;

   // An empty queue lets a new request bypass straight into SETUP
   assign start         = (state == IDLE || state == TURN) && (!fifo_empty || bus.req_valid);
   assign next_req      = fifo_empty ? in_req : head;
   assign pop           = start && !fifo_empty;
   assign push          = bus.req_valid && !fifo_full && !(start && fifo_empty);
   assign bus.req_ready = !fifo_full;
   assign bus.busy      = (state != IDLE) || !fifo_empty;

   tivi_req_fifo u_fifo (
      .clk       (clk),
      .resetb    (resetb),
      .push      (push),
      .push_data (in_req),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
`else
   logic ready_q;

   assign start         = ready_q && bus.req_valid;
   assign next_req      = in_req;
   assign bus.req_ready = ready_q;
   assign bus.busy      = (state != IDLE);

   // Ready only while idle: dropped on accept, restored as TURN returns to IDLE
   always_ff @(posedge clk) begin
      if (!resetb) begin
         ready_q <= 1'b1;
      end else if (start) begin
         ready_q <= 1'b0;
      end else if (state == TURN) begin
         ready_q <= 1'b1;
      end
   end
`endif

   // Bus cycle FSM with a single phase down-counter and registered bus outputs
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         lat_write   <= 1'b0;
         csb_q       <= 1'b1;
         rdb_q       <= 1'b1;
         wrb_q       <= 1'b1;
         oe_q        <= 1'b0;
         rs_q        <= 4'd0;
         db_out_q    <= 8'd0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 8'd0;
      end else begin
         rsp_valid_q <= 1'b0;
         if (start) begin
            state     <= SETUP;
            cnt       <= cnt_load(SETUP_CYC);
            lat_write <= next_req.write;
            csb_q     <= 1'b0;
            rs_q      <= next_req.rs;
            db_out_q  <= next_req.wdata;
            oe_q      <= next_req.write;
         end else begin
            case (state)
               SETUP: begin
                  if (cnt == 4'd0) begin
                     state <= STROBE;
                     cnt   <= cnt_load(STROBE_CYC);
                     rdb_q <= lat_write;
                     wrb_q <= !lat_write;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               STROBE: begin
                  if (cnt == 4'd0) begin
                     state <= HOLD;
                     cnt   <= cnt_load(HOLD_CYC);
                     rdb_q <= 1'b1;
                     wrb_q <= 1'b1;
                     if (!lat_write) rdata_q <= bus.db_in;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               HOLD: begin
                  if (cnt == 4'd0) begin
                     state       <= TURN;
                     cnt         <= 4'd0;
                     csb_q       <= 1'b1;
                     oe_q        <= 1'b0;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               TURN:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.csb       = csb_q;
   assign bus.rdb       = rdb_q;
   assign bus.wrb       = wrb_q;
   assign bus.db_oe     = oe_q;
   assign bus.rs        = rs_q;
   assign bus.db_out    = db_out_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_tivi_bus_master.sv
// tb/tb_tivi_bus_master.sv - directed self-checking bench for tivi_bus_master
module tb_tivi_bus_master;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic       use_b = 1'b0;
   logic       tb_valid = 1'b0;
   logic       tb_write = 1'b0;
   logic [3:0] tb_rs = 4'd0;
   logic [7:0] tb_wdata = 8'd0;
   logic [7:0] tb_db_in = 8'hEE;
   int         vecs = 0;
   int         errs = 0;
   int         inv_err = 0;
   logic [7:0] exp_rd [2];

   tivi_bus_master_if bifa ();
   tivi_bus_master_if bifb ();

   assign bifa.req_valid = tb_valid && !use_b;
   assign bifb.req_valid = tb_valid && use_b;
   assign bifa.req_write = tb_write;
   assign bifb.req_write = tb_write;
   assign bifa.req_rs    = tb_rs;
   assign bifb.req_rs    = tb_rs;
   assign bifa.req_wdata = tb_wdata;
   assign bifb.req_wdata = tb_wdata;
   assign bifa.db_in     = tb_db_in;
   assign bifb.db_in     = tb_db_in;

   tivi_bus_master dut_a (.clk(clk), .resetb(resetb), .bus(bifa));
   tivi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1))
      dut_b (.clk(clk), .resetb(resetb), .bus(bifb));

   always #5 clk = ~clk;

   // {csb, rdb, wrb, db_oe, rsp_valid, busy}
   logic [5:0] ctl_a, ctl_b, o_ctl;
   logic [3:0] o_rs;
   logic [7:0] o_dbout, o_rdata;
   logic       o_ready;
   assign ctl_a   = {bifa.csb, bifa.rdb, bifa.wrb, bifa.db_oe, bifa.rsp_valid, bifa.busy};
   assign ctl_b   = {bifb.csb, bifb.rdb, bifb.wrb, bifb.db_oe, bifb.rsp_valid, bifb.busy};
   assign o_ctl   = use_b ? ctl_b : ctl_a;
   assign o_rs    = use_b ? bifb.rs : bifa.rs;
   assign o_dbout = use_b ? bifb.db_out : bifa.db_out;
   assign o_rdata = use_b ? bifb.rsp_rdata : bifa.rsp_rdata;
   assign o_ready = use_b ? bifb.req_ready : bifa.req_ready;

   // Bus protocol invariants on both masters
   always @(negedge clk) begin
      if (resetb) begin
         if ((!bifa.rdb && !bifa.wrb) || ((!bifa.rdb || !bifa.wrb) && bifa.csb) ||
             (!bifa.rdb && bifa.db_oe)) inv_err++;
         if ((!bifb.rdb && !bifb.wrb) || ((!bifb.rdb || !bifb.wrb) && bifb.csb) ||
             (!bifb.rdb && bifb.db_oe)) inv_err++;
      end
   end

   task automatic wait_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 60 && (bifa.busy || bifb.busy); i++) wait_cyc();
      vecs++;
      if (bifa.busy || bifb.busy) begin
         errs++;
         $display("FAIL idle_timeout: busy_a=%b busy_b=%b want 0", bifa.busy, bifb.busy);
      end
   endtask

   // One request on the selected master, checked every cycle until idle again
   task automatic check_txn(input bit b, input bit wr, input logic [3:0] rsel,
                            input logic [7:0] wd, input logic [7:0] dbv,
                            input int s, input int p, input int h, input string nm);
      int         t;
      logic [5:0] exp_ctl;
      logic       strobe;
      use_b    = b;
      t        = s + p + h;
      tb_valid = 1'b1; tb_write = wr; tb_rs = rsel; tb_wdata = wd; tb_db_in = 8'hEE;
      vecs++;
      if (o_ready !== 1'b1) begin
         errs++; $display("FAIL %s_ready0: got %b want 1", nm, o_ready);
      end
      wait_cyc();
      tb_valid = 1'b0; tb_write = !wr; tb_rs = ~rsel; tb_wdata = ~wd;
      for (int k = 1; k <= t + 2; k++) begin
         tb_db_in = (k == s + p) ? dbv : 8'hEE;
         strobe   = (k > s) && (k <= s + p);
         exp_ctl  = {!(k <= t), !(strobe && !wr), !(strobe && wr), wr && (k <= t),
                     k == t + 1, k <= t + 1};
         vecs++;
         if (o_ctl !== exp_ctl) begin
            errs++; $display("FAIL %s_ctl cyc%0d: got %b want %b", nm, k, o_ctl, exp_ctl);
         end
         if (k <= t + 1) begin
            vecs++;
            if (o_rs !== rsel) begin
               errs++; $display("FAIL %s_rs cyc%0d: got %h want %h", nm, k, o_rs, rsel);
            end
         end
         if (wr && k <= t) begin
            vecs++;
            if (o_dbout !== wd) begin
               errs++; $display("FAIL %s_dbout cyc%0d: got %h want %h", nm, k, o_dbout, wd);
            end
         end
         if (k == t + 1) begin
            if (!wr) exp_rd[b] = dbv;
            vecs++;
            if (o_rdata !== exp_rd[b]) begin
               errs++; $display("FAIL %s_rdata: got %h want %h", nm, o_rdata, exp_rd[b]);
            end
         end
         if (k == t + 2) begin
            vecs++;
            if (o_ready !== 1'b1) begin
               errs++; $display("FAIL %s_ready_end: got %b want 1", nm, o_ready);
            end
         end
         wait_cyc();
      end
      tb_db_in = 8'hEE;
   endtask

   task automatic test_reset;
      resetb = 1'b0;
      wait_cyc();
      wait_cyc();
      vecs++;
      if ({ctl_a, bifa.rs, bifa.db_out, bifa.rsp_rdata, bifa.req_ready} !== {6'b111000, 4'h0, 8'h00, 8'h00, 1'b1}) begin
         errs++; $display("FAIL reset_a: got %b/%h/%h/%h/%b", ctl_a, bifa.rs, bifa.db_out, bifa.rsp_rdata, bifa.req_ready);
      end
      vecs++;
      if ({ctl_b, bifb.rs, bifb.db_out, bifb.rsp_rdata, bifb.req_ready} !== {6'b111000, 4'h0, 8'h00, 8'h00, 1'b1}) begin
         errs++; $display("FAIL reset_b: got %b/%h/%h/%h/%b", ctl_b, bifb.rs, bifb.db_out, bifb.rsp_rdata, bifb.req_ready);
      end
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      resetb = 1'b1;
      wait_cyc();
   endtask

   task automatic test_write;
      check_txn(1'b0, 1'b1, 4'h3, 8'hA5, 8'h00, 2, 4, 2, "write");
   endtask

   task automatic test_read;
      check_txn(1'b0, 1'b0, 4'h7, 8'h00, 8'h5C, 2, 4, 2, "read");
   endtask

   task automatic test_min_timing;
      check_txn(1'b1, 1'b1, 4'hA, 8'h5A, 8'h00, 1, 1, 1, "min_wr");
      check_txn(1'b1, 1'b0, 4'h2, 8'h00, 8'hC3, 1, 1, 1, "min_rd");
      vecs++;
      if (inv_err !== 0) begin
         errs++; $display("FAIL invariants: got %0d violations want 0", inv_err);
      end
   endtask

   task automatic test_abort;
      int rsp_seen;
      use_b = 1'b0;
      tb_valid = 1'b1; tb_write = 1'b1; tb_rs = 4'h5; tb_wdata = 8'h3C;
      wait_cyc();
      tb_valid = 1'b0;
      for (int k = 1; k < 4; k++) wait_cyc();
      vecs++;
      if (bifa.wrb !== 1'b0) begin
         errs++; $display("FAIL abort_strobe: wrb got %b want 0", bifa.wrb);
      end
      resetb = 1'b0;
      wait_cyc();
      vecs++;
      if ({bifa.csb, bifa.rdb, bifa.wrb, bifa.db_oe, bifa.rsp_valid} !== 5'b11100) begin
         errs++; $display("FAIL abort_release: got %b want 11100",
                          {bifa.csb, bifa.rdb, bifa.wrb, bifa.db_oe, bifa.rsp_valid});
      end
      resetb = 1'b1;
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      rsp_seen = 0;
      for (int k = 0; k < 10; k++) begin
         if (bifa.rsp_valid) rsp_seen++;
         wait_cyc();
      end
      vecs++;
      if (rsp_seen !== 0) begin
         errs++; $display("FAIL abort_no_rsp: got %0d rsp want 0", rsp_seen);
      end
      check_txn(1'b0, 1'b0, 4'h1, 8'h00, 8'h96, 2, 4, 2, "post_abort");
   endtask

`ifdef TIVI_BUSM_FIFO_EN
   task automatic test_back_to_back;
      int acc_t [5];
      int rsp_t [5];
      logic [3:0] rsp_rs [5];
      logic csb_next [5];
      int idx;
      int n;
      int t;
      logic acc;
      use_b = 1'b0;
      idx = 0;
      t = 0;
      while (idx < 5 && t < 20) begin
         tb_valid = 1'b1; tb_write = 1'b1; tb_rs = 4'(idx + 1); tb_wdata = 8'(8'h10 + idx);
         acc = bifa.req_ready;
         if (acc) acc_t[idx] = t;
         wait_cyc();
         t++;
         if (acc) idx++;
      end
      tb_valid = 1'b0;
      vecs++;
      if (idx !== 5) begin
         errs++; $display("FAIL fifo_accepts: got %0d want 5", idx);
      end
      for (int i = 0; i < idx; i++) begin
         vecs++;
         if (acc_t[i] !== i) begin
            errs++; $display("FAIL fifo_acc_cycle%0d: got %0d want %0d", i, acc_t[i], i);
         end
      end
      vecs++;
      if (bifa.req_ready !== 1'b0) begin
         errs++; $display("FAIL fifo_full_ready: got %b want 0", bifa.req_ready);
      end
      n = 0;
      while (t < 60) begin
         if (n > 0 && t == rsp_t[n-1] + 1) csb_next[n-1] = bifa.csb;
         if (bifa.rsp_valid && n < 5) begin
            rsp_t[n] = t; rsp_rs[n] = bifa.rs; n++;
         end
         wait_cyc();
         t++;
      end
      vecs++;
      if (n !== 5) begin
         errs++; $display("FAIL fifo_rsp_count: got %0d want 5", n);
      end
      for (int i = 0; i < n; i++) begin
         vecs++;
         if (rsp_t[i] !== 9 + 8 * i || rsp_rs[i] !== 4'(i + 1)) begin
            errs++; $display("FAIL fifo_rsp%0d: got cyc%0d rs%h want cyc%0d rs%h",
                             i, rsp_t[i], rsp_rs[i], 9 + 8 * i, 4'(i + 1));
         end
         vecs++;
         if (csb_next[i] !== (i == 4)) begin
            errs++; $display("FAIL fifo_csb_gap%0d: got %b want %b", i, csb_next[i], i == 4);
         end
      end
   endtask
`else
   task automatic test_back_to_back;
      int acc_t [4];
      int n;
      use_b = 1'b0;
      n = 0;
      tb_valid = 1'b1; tb_write = 1'b1; tb_rs = 4'h4; tb_wdata = 8'h77;
      for (int t = 0; t < 35; t++) begin
         if (bifa.req_ready && n < 4) begin
            acc_t[n] = t; n++;
         end
         wait_cyc();
      end
      tb_valid = 1'b0;
      vecs++;
      if (n !== 4) begin
         errs++; $display("FAIL b2b_accepts: got %0d want 4", n);
      end
      for (int i = 1; i < n; i++) begin
         vecs++;
         if (acc_t[i] - acc_t[i-1] !== 10) begin
            errs++; $display("FAIL b2b_spacing%0d: got %0d want 10", i, acc_t[i] - acc_t[i-1]);
         end
      end
   endtask
`endif

   initial begin
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      #1;
      test_reset();
      test_write();
      test_read();
      test_min_timing();
      test_abort();
      test_back_to_back();
      wait_idle();
      vecs++;
      if (inv_err !== 0) begin
         errs++; $display("FAIL invariants_final: got %0d violations want 0", inv_err);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
